// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word RAM between the instruction
// fetch port and the load/store port. Partial stores run as read-modify-write.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-break; otherwise the
// data port always wins a tie).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WMASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR} state_e;

  state_e              state_q, state_d;
  logic                own_d_q, own_d_d;     // 1: read in flight belongs to D
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
  logic                pick_d;
`ifdef MEM_ARB_RR_EN
  logic                last_d_q, last_d_d;   // 1: last grant went to D
`endif

  // Next state, grants and RAM control; everything is forced quiet while
  // reset_n is low so a write-back in progress is dropped immediately.
  always_comb begin
    state_d  = state_q;
    own_d_d  = own_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    mem_a    = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
`ifdef MEM_ARB_RR_EN
    pick_d   = d_req && (!i_req || !last_d_q);
`else
    pick_d   = d_req;
`endif
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            d_gnt = 1'b1;
            if (!d_we) begin
              mem_a   = d_addr & WMASK;
              own_d_d = 1'b1;
              state_d = RD_WAIT;
            end else if (&d_be) begin
              mem_a  = d_addr & WMASK;
              mem_we = 1'b1;
              mem_wd = d_wdata;
            end else if (|d_be) begin
              // partial store: fetch the old word, merge next cycle
              mem_a   = d_addr & WMASK;
              addr_d  = d_addr & WMASK;
              wdata_d = d_wdata;
              be_d    = d_be;
              state_d = RMW_WR;
            end
          end else if (i_req) begin
            i_gnt   = 1'b1;
            mem_a   = i_addr & WMASK;
            own_d_d = 1'b0;
            state_d = RD_WAIT;
          end
        end
        RD_WAIT: begin
          i_rvalid = !own_d_q;
          d_rvalid = own_d_q;
          state_d  = IDLE;
        end
        RMW_WR: begin
          mem_a  = addr_q;
          mem_we = 1'b1;
          for (int k = 0; k < NB; k++)
            mem_wd[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : mem_rd[8*k +: 8];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer follows every grant.
  always_comb begin
    last_d_d = last_d_q;
    if (d_gnt)      last_d_d = 1'b1;
    else if (i_gnt) last_d_d = 1'b0;
  end

  // Pointer register; reset favours the instruction port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_d_q <= 1'b1;
    else          last_d_q <= last_d_d;
  end
`endif

  // State, RMW latches and held read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      own_d_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      if (i_rvalid) i_rdata_q <= mem_rd;
      if (d_rvalid) d_rdata_q <= mem_rd;
    end
  end

  assign i_rdata = i_rvalid ? mem_rd : i_rdata_q;
  assign d_rdata = d_rvalid ? mem_rd : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, transaction-level reference model
// compared every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_a, mem_wd;
  logic [31:0] mem_rd = '0;

  int checks = 0, errors = 0;
  logic [31:0] ram  [1024];
  logic [31:0] gmem [1024];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Synchronous RAM with registered read.
  always @(posedge clk) begin
    if (mem_we) ram[(mem_a >> 2) % 1024] <= mem_wd;
    mem_rd <= ram[(mem_a >> 2) % 1024];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: pending work after a grant, golden memory image.
  int          m_kind = 0;   // 0 none, 1 fetch result, 2 load result, 3 merge write
  int          m_idx = 0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_last_i = '0, m_last_d = '0;
  bit          m_last_was_d = 1'b1;

  always @(negedge clk) begin
    logic [4:0]  e_ctl;
    logic [31:0] e_a, e_wd, e_ir, e_dr;
    bit          win_d;
    e_ctl = '0; e_a = '0; e_wd = '0;
    if (!reset_n) begin
      m_kind = 0; m_last_i = '0; m_last_d = '0; m_last_was_d = 1'b1;
    end else if (m_kind == 1) begin
      e_ctl[3] = 1'b1; m_last_i = gmem[m_idx]; m_kind = 0;
    end else if (m_kind == 2) begin
      e_ctl[1] = 1'b1; m_last_d = gmem[m_idx]; m_kind = 0;
    end else if (m_kind == 3) begin
      e_ctl[0] = 1'b1; e_a = m_idx * 4;
      for (int k = 0; k < 4; k++)
        e_wd[8*k +: 8] = m_be[k] ? m_data[8*k +: 8] : gmem[m_idx][8*k +: 8];
      gmem[m_idx] = e_wd; m_kind = 0;
    end else if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
      win_d = d_req && (!i_req || !m_last_was_d);
`else
      win_d = d_req;
`endif
      m_last_was_d = win_d;
      if (!win_d) begin
        e_ctl[4] = 1'b1; m_idx = (i_addr >> 2) % 1024; e_a = m_idx * 4; m_kind = 1;
      end else begin
        e_ctl[2] = 1'b1; m_idx = (d_addr >> 2) % 1024;
        if (!d_we) begin
          e_a = m_idx * 4; m_kind = 2;
        end else if (d_be == 4'hF) begin
          e_a = m_idx * 4; e_ctl[0] = 1'b1; e_wd = d_wdata; gmem[m_idx] = d_wdata;
        end else if (d_be != 4'h0) begin
          e_a = m_idx * 4; m_data = d_wdata; m_be = d_be; m_kind = 3;
        end
      end
    end
    e_ir = m_last_i; e_dr = m_last_d;
    chk("ctl{ig,irv,dg,drv,we}", {27'd0, i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we}, {27'd0, e_ctl});
    chk("mem_a", mem_a, e_a);
    chk("mem_wd", mem_wd, e_wd);
    chk("i_rdata", i_rdata, e_ir);
    chk("d_rdata", d_rdata, e_dr);
  end

  logic [31:0] g_a, g_wd;
  logic        g_we;

  task automatic i_access(input logic [31:0] a);
    int n;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = a; n = 0;
    do begin @(negedge clk); n++; end while (!i_gnt && n < 20);
    if (!i_gnt) chk("i_gnt_wait", {31'd0, i_gnt}, 32'd1);
    g_a = mem_a; g_we = mem_we; g_wd = mem_wd;
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_be = be; d_wdata = wd; n = 0;
    do begin @(negedge clk); n++; end while (!d_gnt && n < 20);
    if (!d_gnt) chk("d_gnt_wait", {31'd0, d_gnt}, 32'd1);
    g_a = mem_a; g_we = mem_we; g_wd = mem_wd;
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[4]  = 32'h12345678;
    ram[16] = 32'h11223344;
    ram[20] = 32'hCAFEF00D;
    for (int i = 0; i < 1024; i++) gmem[i] = ram[i];

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);

    // fetch with unaligned address and then aligned
    i_access(32'h13);
    chk("fetch13_mem_a", g_a, 32'h10);
    @(negedge clk);
    chk("fetch_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("fetch_rdata", i_rdata, 32'h12345678);
    i_access(32'h10);
    chk("fetch10_mem_a", g_a, 32'h10);

    // full store then load
    d_access(1'b1, 32'h20, 4'hF, 32'hDEADBEEF);
    chk("store_we", {31'd0, g_we}, 32'd1);
    chk("store_wd", g_wd, 32'hDEADBEEF);
    @(negedge clk);
    chk("store_ram", ram[8], 32'hDEADBEEF);
    d_access(1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    chk("load_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("load_rdata", d_rdata, 32'hDEADBEEF);

    // partial store (byte lane 2)
    d_access(1'b1, 32'h40, 4'b0100, 32'h00AA0000);
    chk("rmw_grant_we", {31'd0, g_we}, 32'd0);
    @(negedge clk);
    chk("rmw_we", {31'd0, mem_we}, 32'd1);
    chk("rmw_wd", mem_wd, 32'h11AA3344);
    d_access(1'b0, 32'h40, 4'h0, 32'h0);
    @(negedge clk);
    chk("rmw_load", d_rdata, 32'h11AA3344);

    // zero byte-enable store is a no-op
    d_access(1'b1, 32'h60, 4'h0, 32'h55555555);
    chk("be0_grant_we", {31'd0, g_we}, 32'd0);
    @(negedge clk);
    chk("be0_we_after", {31'd0, mem_we}, 32'd0);
    chk("be0_ram", ram[24], 32'h0);

    // reset during the write-back of a partial store
    d_access(1'b1, 32'h50, 4'b0001, 32'h000000EE);
    chk("rmw2_we_before_rst", {31'd0, mem_we}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_we", {31'd0, mem_we}, 32'd0);
    chk("rst_async_i_rdata", i_rdata, 32'h0);
    chk("rst_async_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ram_kept", ram[20], 32'hCAFEF00D);
    d_access(1'b0, 32'h50, 4'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_load", d_rdata, 32'hCAFEF00D);

    // both ports loading for 8 cycles
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'h0;
    seq = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_gnt) seq = {seq[23:0], 8'h49};
      if (d_gnt) seq = {seq[23:0], 8'h44};
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_RR_EN
    chk("arb_seq_IDID", seq, 32'h49444944);
`else
    chk("arb_seq_DDDD", seq, 32'h44444444);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 4096-byte unified RAM between the instruction-fetch port and the load/store port of the MIPS core. It accepts one word request at a time, drives the RAM address, write-enable and write-data lines, and returns read data with a valid strobe. Partial-word stores (`sb`/`sh`) run as read-modify-write, because the RAM only writes whole words.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width of both requesters and the RAM.
- `DATA_W`, default 32: word width; fixed at 32 (four bytes).

Ports:
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction-fetch read request.
- `i_addr`  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- `i_gnt`  out  1  one-cycle pulse: fetch request accepted.
- `i_rvalid`  out  1  one-cycle pulse: `i_rdata` is valid.
- `i_rdata`  out  32  fetched word.
- `d_req`  in  1  load/store request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address; bits [1:0] are ignored.
- `d_be`  in  4  store byte enables. `d_be[3]` selects `d_wdata[31:24]`, which goes to the lowest byte address (big-endian).
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  one-cycle pulse: data request accepted.
- `d_rvalid`  out  1  one-cycle pulse: `d_rdata` is valid (loads only).
- `d_rdata`  out  32  loaded word.
- `mem_a`  out  ADDR_W  RAM byte address, always word-aligned.
- `mem_we`  out  1  RAM write enable.
- `mem_wd`  out  32  RAM write data.
- `mem_rd`  in  32  RAM read data. It is registered inside the RAM and valid the cycle after `mem_a` is presented.

## Operation
- States:
  - `IDLE`: accepts requests.
  - `RD_WAIT`: read in flight. A register records which port (I or D) owns it.
  - `RMW_WR`: write-back phase of a partial store.
- Requesters hold `req`, address, data and `be` stable until they see `gnt`. They may deassert `req` in the cycle after `gnt`.
- In `IDLE`, `gnt` is combinational from `req`. In the grant cycle `mem_a = {addr[ADDR_W-1:2], 2'b00}`.
- Both requests high together: arbitration decides the winner (see Configuration). The loser waits; it is never granted in the same cycle.
- Grant to a fetch or a load: `mem_we=0`, next state `RD_WAIT`.
- `RD_WAIT`:
  - The owner's `rvalid` is 1 and its `rdata = mem_rd`.
  - Next state `IDLE`. No new grant is issued in this cycle.
- Store with `d_be = 4'hF`:
  - Grant cycle drives `mem_we=1` and `mem_wd = d_wdata`.
  - State stays `IDLE`. There is no `rvalid`.
- Store with `d_be = 4'h0`: `d_gnt` pulses with no RAM access. This is a legal no-op.
- Any other store (partial):
  - Grant cycle issues a read (`mem_we=0`) and latches the address, data and `be`. Next state `RMW_WR`.
  - In `RMW_WR`: `mem_a` is the latched address and `mem_we=1`.
  - `mem_wd` takes byte lane k from the latched data where `be[k]=1`, otherwise from `mem_rd`. Then back to `IDLE`.
  - No `d_rvalid` is produced.
- Outside active cycles: `mem_we=0`, `mem_a=0`, `mem_wd=0`.
- The `rdata` outputs hold their last value between `rvalid` pulses.

## Timing
- Reset:
  - State `IDLE`; all `gnt`/`rvalid` outputs 0.
  - `i_rdata`, `d_rdata`, `mem_a`, `mem_wd` are 0; `mem_we` is 0.
  - Round-robin pointer set to favour the instruction port.
- Latencies:
  - Read: grant at cycle N, `rvalid` at N+1. Peak throughput is one read every 2 cycles.
  - Full-word store: 1 cycle; back-to-back full stores accepted every cycle.
  - Partial store: 2 cycles; the RAM write lands at the end of cycle N+1.
- `reset_n` falling mid-operation:
  - `mem_we` drops immediately (asynchronous).
  - A pending `rvalid` or RMW write-back is discarded, and the RAM word stays unmodified.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the port that was not granted last wins; the pointer updates on every grant. The pointer starts at the instruction port after reset.
- `MEM_ARB_RR_EN` undefined: fixed priority, data port always wins ties. There is no pointer register.

## Test plan
- Fetch of preloaded word 0x12345678 at address 0x10 → `i_gnt` at N, `i_rvalid=1` and `i_rdata=0x12345678` at N+1. `mem_a=0x10`, and `mem_a=0x10` also when `i_addr=0x13`.
- Full store of 0xDEADBEEF at 0x20, then a load from 0x20 → single-cycle write with `mem_we=1`. Load returns 0xDEADBEEF one cycle after its grant.
- Word 0x11223344 at 0x40; store with `d_be=4'b0100`, `d_wdata=0x00AA0000` → `mem_we=1` at N+1 with `mem_wd=0x11AA3344`. A later load returns 0x11AA3344.
- `i_req` and `d_req` held high for 8 cycles, both loads:
  - With `MEM_ARB_RR_EN`: grants alternate I, D, I, D (I first).
  - Without it: every grant goes to D.
- `reset_n` pulsed low during `RMW_WR` → `mem_we` falls asynchronously. The word keeps its old value, all outputs read 0, and the next request is serviced normally.
- Store with `d_be=4'h0` → `d_gnt` pulses, `mem_we` stays 0, and no state change occurs.
